batch_conflict_manager: RTL and testbench

- Global dependency-conflict filter between the input stream and the parallel batcher instances.
- Keeps a slot table of in-flight batches (read/write dependency bitmaps plus owner ID) and the OR-union of their bitmaps.
- Checks each incoming transaction combinationally against that union and flags RAW/WAW/WAR hazards, so upstream logic can drop the transaction.
- Keeps saturating conflict statistics.

---
 rtl/batch_conflict_manager_if.sv | 49 ++++
 rtl/batch_conflict_manager.sv | 130 +++++++++++++
 tb/tb_batch_conflict_manager.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/batch_conflict_manager_if.sv
// Bus bundle for batch_conflict_manager: candidate check, slot
// registration/release and the global union / statistics outputs.
interface batch_conflict_manager_if #(
  parameter int MAX_DEPENDENCIES = 256
);
  logic                        txn_valid;
  logic [MAX_DEPENDENCIES-1:0] txn_read_deps;
  logic [MAX_DEPENDENCIES-1:0] txn_write_deps;
  logic [63:0]                 txn_owner_id;
  logic                        has_conflict;
  logic [2:0]                  conflict_type;

  logic                        new_batch_valid;
  logic [3:0]                  new_batch_id;
  logic [MAX_DEPENDENCIES-1:0] new_batch_read_deps;
  logic [MAX_DEPENDENCIES-1:0] new_batch_write_deps;
  logic [63:0]                 new_batch_owner_id;
  logic                        batch_completed;
  logic [3:0]                  batch_id;

  logic [MAX_DEPENDENCIES-1:0] global_read_dependencies;
  logic [MAX_DEPENDENCIES-1:0] global_write_dependencies;
  logic [31:0]                 global_conflicts;
  logic [31:0]                 raw_conflict_count;
  logic [31:0]                 waw_conflict_count;
  logic [31:0]                 war_conflict_count;

  modport master (
    output txn_valid, txn_read_deps, txn_write_deps, txn_owner_id,
    output new_batch_valid, new_batch_id, new_batch_read_deps,
    output new_batch_write_deps, new_batch_owner_id,
    output batch_completed, batch_id,
    input  has_conflict, conflict_type,
    input  global_read_dependencies, global_write_dependencies,
    input  global_conflicts, raw_conflict_count,
    input  waw_conflict_count, war_conflict_count
  );

  modport slave (
    input  txn_valid, txn_read_deps, txn_write_deps, txn_owner_id,
    input  new_batch_valid, new_batch_id, new_batch_read_deps,
    input  new_batch_write_deps, new_batch_owner_id,
    input  batch_completed, batch_id,
    output has_conflict, conflict_type,
    output global_read_dependencies, global_write_dependencies,
    output global_conflicts, raw_conflict_count,
    output waw_conflict_count, war_conflict_count
  );
endinterface

// File: rtl/batch_conflict_manager.sv
// Slot table of in-flight batches with RAW/WAW/WAR hazard check.
// Optional CM_OWNER_BYPASS_EN: slots owned by the candidate are skipped.
module batch_conflict_manager #(
  parameter int MAX_DEPENDENCIES = 256,
  parameter int MAX_BATCHES      = 16
) (
  input logic clk,
  input logic rst_n,
  batch_conflict_manager_if.slave bus
);
  typedef logic [MAX_DEPENDENCIES-1:0] dep_t;

  logic [MAX_BATCHES-1:0] valid_q, valid_d;
  dep_t                   rd_q  [MAX_BATCHES];
  dep_t                   rd_d  [MAX_BATCHES];
  dep_t                   wr_q  [MAX_BATCHES];
  dep_t                   wr_d  [MAX_BATCHES];
  logic [63:0]            own_q [MAX_BATCHES];
  logic [63:0]            own_d [MAX_BATCHES];

  logic [31:0] gc_q, raw_q, waw_q, war_q;

  logic [MAX_BATCHES-1:0] elig;
  dep_t gr, gw, er, ew;
  logic raw, waw, war;
  logic [2:0] ctype;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic        en
  );
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

`ifdef CM_OWNER_BYPASS_EN
  always_comb begin
    for (int i = 0; i < MAX_BATCHES; i++)
      elig[i] = valid_q[i] && (own_q[i] != bus.txn_owner_id);
  end
`else
  logic unused_owner;
  always_comb begin
    unused_owner = ^bus.txn_owner_id;
    for (int i = 0; i < MAX_BATCHES; i++) begin
      elig[i]      = valid_q[i];
      unused_owner = unused_owner ^ (^own_q[i]);
    end
  end
`endif

  always_comb begin
    gr = '0;
    gw = '0;
    er = '0;
    ew = '0;
    for (int i = 0; i < MAX_BATCHES; i++) begin
      if (valid_q[i]) begin
        gr = gr | rd_q[i];
        gw = gw | wr_q[i];
      end
      if (elig[i]) begin
        er = er | rd_q[i];
        ew = ew | wr_q[i];
      end
    end
  end

  always_comb begin
    raw   = |(bus.txn_read_deps & ew);
    waw   = |(bus.txn_write_deps & ew);
    war   = |(bus.txn_write_deps & er);
    ctype = bus.txn_valid ? {raw, waw, war} : 3'b000;
  end

  // Release is applied before registration so a same-slot race reloads.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < MAX_BATCHES; i++) begin
      rd_d[i]  = rd_q[i];
      wr_d[i]  = wr_q[i];
      own_d[i] = own_q[i];
      if (bus.batch_completed && bus.batch_id == 4'(i)) begin
        valid_d[i] = 1'b0;
        rd_d[i]    = '0;
        wr_d[i]    = '0;
      end
      if (bus.new_batch_valid && bus.new_batch_id == 4'(i)) begin
        valid_d[i] = 1'b1;
        rd_d[i]    = bus.new_batch_read_deps;
        wr_d[i]    = bus.new_batch_write_deps;
        own_d[i]   = bus.new_batch_owner_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < MAX_BATCHES; i++) begin
        rd_q[i]  <= '0;
        wr_q[i]  <= '0;
        own_q[i] <= '0;
      end
      gc_q  <= '0;
      raw_q <= '0;
      waw_q <= '0;
      war_q <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < MAX_BATCHES; i++) begin
        rd_q[i]  <= rd_d[i];
        wr_q[i]  <= wr_d[i];
        own_q[i] <= own_d[i];
      end
      gc_q  <= sat_inc(gc_q, |ctype);
      raw_q <= sat_inc(raw_q, ctype[2]);
      waw_q <= sat_inc(waw_q, ctype[1]);
      war_q <= sat_inc(war_q, ctype[0]);
    end
  end

  assign bus.conflict_type             = ctype;
  assign bus.has_conflict              = |ctype;
  assign bus.global_read_dependencies  = gr;
  assign bus.global_write_dependencies = gw;
  assign bus.global_conflicts          = gc_q;
  assign bus.raw_conflict_count        = raw_q;
  assign bus.waw_conflict_count        = waw_q;
  assign bus.war_conflict_count        = war_q;
endmodule

// File: tb/tb_batch_conflict_manager.sv
// Scoreboard bench for batch_conflict_manager: stimulus queues expected
// values tagged with a cycle, a negedge monitor pops and compares them.
module tb_batch_conflict_manager;
  localparam int MD = 256;
  localparam int MB = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  batch_conflict_manager_if #(.MAX_DEPENDENCIES(MD)) bus ();

  batch_conflict_manager #(
    .MAX_DEPENDENCIES(MD),
    .MAX_BATCHES(MB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    int         cyc;
    int         sel;
    string      name;
    logic [MD-1:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

`ifdef CM_OWNER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [MD-1:0] observe(input int sel);
    case (sel)
      0: return MD'(bus.has_conflict);
      1: return MD'(bus.conflict_type);
      2: return bus.global_read_dependencies;
      3: return bus.global_write_dependencies;
      4: return MD'(bus.global_conflicts);
      5: return MD'(bus.raw_conflict_count);
      6: return MD'(bus.waw_conflict_count);
      default: return MD'(bus.war_conflict_count);
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [MD-1:0] act;
      e = q.pop_front();
      act = observe(e.sel);
      vectors++;
      if (e.cyc < cyc) begin
        miscompares++;
        $display("FAIL %s: check expired at cycle %0d", e.name, cyc);
      end else if (act !== e.val) begin
        miscompares++;
        $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
      end
    end
  end

  task automatic expect_v(input string n, input int s, input logic [MD-1:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.sel  = s;
    e.name = n;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.txn_valid            = 1'b0;
    bus.txn_read_deps        = '0;
    bus.txn_write_deps       = '0;
    bus.txn_owner_id         = '0;
    bus.new_batch_valid      = 1'b0;
    bus.new_batch_id         = '0;
    bus.new_batch_read_deps  = '0;
    bus.new_batch_write_deps = '0;
    bus.new_batch_owner_id   = '0;
    bus.batch_completed      = 1'b0;
    bus.batch_id             = '0;
  endtask

  task automatic txn(input logic [MD-1:0] r, input logic [MD-1:0] w,
                     input logic [63:0] o);
    bus.txn_valid      = 1'b1;
    bus.txn_read_deps  = r;
    bus.txn_write_deps = w;
    bus.txn_owner_id   = o;
  endtask

  task automatic reg_slot(input logic [3:0] id, input logic [MD-1:0] r,
                          input logic [MD-1:0] w, input logic [63:0] o);
    bus.new_batch_valid      = 1'b1;
    bus.new_batch_id         = id;
    bus.new_batch_read_deps  = r;
    bus.new_batch_write_deps = w;
    bus.new_batch_owner_id   = o;
  endtask

  task automatic rel_slot(input logic [3:0] id);
    bus.batch_completed = 1'b1;
    bus.batch_id        = id;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    txn(1, 2, 0);
    expect_v("rst_hc", 0, 0);
    expect_v("rst_ct", 1, 0);
    expect_v("rst_gr", 2, 0);
    expect_v("rst_gw", 3, 0);
    expect_v("rst_gc", 4, 0);
    expect_v("rst_raw", 5, 0);
    expect_v("rst_waw", 6, 0);
    expect_v("rst_war", 7, 0);
    tick();

    idle();
    reg_slot(0, 'h0F, 'hF0, 5);
    expect_v("reg_latency_gr", 2, 0);
    tick();

    idle();
    txn('h10, 0, 7);
    expect_v("s0_gr", 2, 'h0F);
    expect_v("s0_gw", 3, 'hF0);
    expect_v("raw_ct", 1, 3'b100);
    expect_v("raw_hc", 0, 1);
    expect_v("raw_gc_before", 4, 0);
    tick();

    txn(0, 'h11, 7);
    expect_v("ww_ct", 1, 3'b011);
    expect_v("ww_hc", 0, 1);
    expect_v("gc_after_raw", 4, 1);
    expect_v("raw_after_raw", 5, 1);
    expect_v("waw_after_raw", 6, 0);
    tick();

    idle();
    expect_v("idle_ct", 1, 0);
    expect_v("idle_hc", 0, 0);
    expect_v("gc_after_ww", 4, 2);
    expect_v("raw_after_ww", 5, 1);
    expect_v("waw_after_ww", 6, 1);
    expect_v("war_after_ww", 7, 1);
    reg_slot(3, 0, 'h100, 1);
    rel_slot(0);
    tick();

    idle();
    expect_v("swap_gr", 2, 0);
    expect_v("swap_gw", 3, 'h100);
    rel_slot(3);
    tick();

    idle();
    expect_v("empty_gr", 2, 0);
    expect_v("empty_gw", 3, 0);
    reg_slot(2, 'h40, 0, 0);
    tick();

    idle();
    expect_v("s2_gr", 2, 'h40);
    rel_slot(2);
    reg_slot(2, 'h8, 0, 0);
    tick();

    idle();
    expect_v("race_gr", 2, 'h8);
    expect_v("race_gw", 3, 0);
    reg_slot(4'(MB), 'h1000, 'h1000, 0);
    tick();

    idle();
    rel_slot(4'(MB + 1));
    expect_v("oob_reg_gr", 2, 'h8);
    expect_v("oob_reg_gw", 3, 0);
    txn(0, 'h8, 3);
    expect_v("war_ct", 1, 3'b001);
    tick();

    idle();
    expect_v("oob_rel_gr", 2, 'h8);
    expect_v("gc_after_war", 4, 3);
    expect_v("war_after_war", 7, 2);
    reg_slot(1, 0, 'h4, 9);
    tick();

    idle();
    txn('h4, 0, 9);
    expect_v("byp_gw", 3, 'h4);
    expect_v("byp_ct", 1, BYP ? 3'b000 : 3'b100);
    expect_v("byp_hc", 0, BYP ? 0 : 1);
    tick();

    idle();
    expect_v("gc_after_byp", 4, BYP ? 3 : 4);
    expect_v("raw_after_byp", 5, BYP ? 1 : 2);
    tick();

    #1 rst_n = 1'b0;
    expect_v("arst_gr", 2, 0);
    expect_v("arst_gw", 3, 0);
    expect_v("arst_gc", 4, 0);
    expect_v("arst_raw", 5, 0);
    expect_v("arst_war", 7, 0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL %s: never checked", e.name);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
